// File: rtl/gpu_cmd_sender_pkg.sv
// Shared types and defaults for the GPU command sender and its queue.
// Holds the issue FSM state encoding and the packed instruction word pair.
package colenda_pkg;

  localparam int CMD_DEPTH = 8;
  localparam int CMD_HOLD  = 2;
  localparam int CMD_GAP   = 2;
  localparam int CMD_W     = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef struct packed {
    logic [CMD_W-1:0] a;
    logic [CMD_W-1:0] b;
  } cmd_t;

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/gpu_cmd_sender_if.sv
// Host command handshake plus FIFO write-side signals of the command sender.
// master = host/test side, slave = gpu_cmd_sender.
interface gpu_cmd_sender_if import colenda_pkg::*; #(
  parameter int DEPTH = CMD_DEPTH
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [CMD_W-1:0]       cmd_dataA;
  logic [CMD_W-1:0]       cmd_dataB;
  logic                   wrfull;
  logic [CMD_W-1:0]       dataA;
  logic [CMD_W-1:0]       dataB;
  logic                   wrreg;
  logic                   busy;
  logic [$clog2(DEPTH):0] level;

  modport master (
    output cmd_valid, cmd_dataA, cmd_dataB, wrfull,
    input  cmd_ready, dataA, dataB, wrreg, busy, level
  );

  modport slave (
    input  cmd_valid, cmd_dataA, cmd_dataB, wrfull,
    output cmd_ready, dataA, dataB, wrreg, busy, level
  );
endinterface

// File: rtl/gpu_cmd_sender_cmd_queue.sv
// Purpose: circular instruction buffer with push/pop and registered occupancy.
// Latency: pushed entry visible at head one cycle after the push edge.
// Backpressure: not_full is combinational from count; pushes while full are dropped here, so callers gate on it.
module cmd_queue import colenda_pkg::*; #(
  parameter int DEPTH = CMD_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  cmd_t                   push_dat,
  input  logic                   pop,
  output cmd_t                   head,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] count_nxt,
  output logic                   not_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  cmd_t          mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign not_full = (count != CNT_MAX);
  assign do_push  = push & not_full;
  assign do_pop   = pop & (count != '0);
  assign head     = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/gpu_cmd_sender.sv
// Purpose: queue host GPU instructions and replay each as a shaped wrreg pulse with stable dataA/dataB.
// Latency: pop one cycle after push into an empty idle queue; HOLD high + GAP low + 1 idle cycle per instruction.
// Backpressure: cmd_ready low while queue full; wrfull sampled only in IDLE. GPU_CMD_SENDER_STATS_EN adds issue/stall counters.
module gpu_cmd_sender import colenda_pkg::*; #(
  parameter int DEPTH       = CMD_DEPTH,
  parameter int HOLD_CYCLES = CMD_HOLD,
  parameter int GAP_CYCLES  = CMD_GAP
) (
  input  logic            clk,
  input  logic            reset,
  gpu_cmd_sender_if.slave bus
`ifdef GPU_CMD_SENDER_STATS_EN
  ,
  output logic [31:0]     issued_count,
  output logic [31:0]     stall_count
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(max2(HOLD_CYCLES, GAP_CYCLES)) + 1;
  localparam logic [PW-1:0] HOLD_LAST = PW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] GAP_LAST  = PW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PH_ONE    = PW'(1);

  state_t           state;
  logic [PW-1:0]    phase;
  cmd_t             in_cmd;
  cmd_t             head;
  logic [CW-1:0]    q_count;
  logic [CW-1:0]    q_count_nxt;
  logic             q_not_full;
  logic             push;
  logic             pop;
  logic             fsm_idle_nxt;
  logic [CMD_W-1:0] data_a;
  logic [CMD_W-1:0] data_b;
  logic             wrreg_q;
  logic             busy_q;

  assign in_cmd = {bus.cmd_dataA, bus.cmd_dataB};
  assign push   = bus.cmd_valid & q_not_full;
  assign pop    = (state == IDLE) && (q_count != '0) && !bus.wrfull;

  // busy is registered, so it is built from where the FSM and queue land after this edge.
  assign fsm_idle_nxt = ((state == IDLE) && !pop) ||
                        ((state == RELEASE) && (phase == GAP_LAST));

  cmd_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_dat  (in_cmd),
    .pop       (pop),
    .head      (head),
    .count     (q_count),
    .count_nxt (q_count_nxt),
    .not_full  (q_not_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      phase   <= '0;
      wrreg_q <= 1'b0;
      data_a  <= '0;
      data_b  <= '0;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= !fsm_idle_nxt || (q_count_nxt != '0);
      case (state)
        IDLE: begin
          if (pop) begin
            data_a  <= head.a;
            data_b  <= head.b;
            phase   <= '0;
            wrreg_q <= 1'b1;
            state   <= ASSERT;
          end
        end
        ASSERT: begin
          if (phase == HOLD_LAST) begin
            phase   <= '0;
            wrreg_q <= 1'b0;
            state   <= RELEASE;
          end else begin
            phase <= phase + PH_ONE;
          end
        end
        RELEASE: begin
          if (phase == GAP_LAST) state <= IDLE;
          else                   phase <= phase + PH_ONE;
        end
        default: begin
          state   <= IDLE;
          wrreg_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = q_not_full;
  assign bus.dataA     = data_a;
  assign bus.dataB     = data_b;
  assign bus.wrreg     = wrreg_q;
  assign bus.busy      = busy_q;
  assign bus.level     = q_count;

`ifdef GPU_CMD_SENDER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issued_count <= '0;
      stall_count  <= '0;
    end else begin
      if (pop && (issued_count != '1))
        issued_count <= issued_count + 32'd1;
      if ((state == IDLE) && (q_count != '0) && bus.wrfull && (stall_count != '1))
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gpu_cmd_sender.sv
// Bench for gpu_cmd_sender: queue-and-timer reference model compared every cycle, plus literal checks.
module tb_gpu_cmd_sender;
  import colenda_pkg::*;

  localparam int D = 8;
  localparam int H = 2;
  localparam int G = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   cmp_en = 0;

  gpu_cmd_sender_if #(.DEPTH(D)) bus ();

`ifdef GPU_CMD_SENDER_STATS_EN
  logic [31:0] issued_count;
  logic [31:0] stall_count;
`endif

  gpu_cmd_sender #(.DEPTH(D), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef GPU_CMD_SENDER_STATS_EN
    ,
    .issued_count (issued_count),
    .stall_count  (stall_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: instructions wait in a queue; an issue may happen when the
  // previous one is at least H+G edges old, the queue is non-empty and wrfull is low.
  logic [63:0] mq[$];
  int          m_since = 1000;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  bit          m_pop;
  bit          m_push;
  logic [63:0] m_in;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_since = 1000;
      m_a = '0;
      m_b = '0;
    end else begin
      m_pop  = (m_since >= H + G) && (mq.size() != 0) && !bus.wrfull;
      m_push = bus.cmd_valid && (mq.size() != D);
      m_in   = {bus.cmd_dataA, bus.cmd_dataB};
      if (m_pop) begin
        {m_a, m_b} = mq.pop_front();
        m_since = 0;
      end else if (m_since < 1000) begin
        m_since++;
      end
      if (m_push) mq.push_back(m_in);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("wrreg", bus.wrreg, m_since < H);
      chk("busy", bus.busy, (m_since < H + G) || (mq.size() != 0));
      chk("level", bus.level, mq.size());
      chk("cmd_ready", bus.cmd_ready, mq.size() != D);
      chk("dataA", bus.dataA, m_a);
      chk("dataB", bus.dataB, m_b);
    end
  end

  // Records every wrreg rising edge with the issue edge number and data.
  int          rise_cyc[$];
  logic [63:0] rise_dat[$];
  logic        wr_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.wrreg && !wr_prev) begin
      rise_cyc.push_back(cyc);
      rise_dat.push_back({bus.dataA, bus.dataB});
    end
    wr_prev = bus.wrreg;
  end

  task automatic push_cmd(input logic [31:0] a, input logic [31:0] b, output int acc);
    bit r;
    acc = -1;
    bus.cmd_valid = 1'b1;
    bus.cmd_dataA = a;
    bus.cmd_dataB = b;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      r = bus.cmd_ready;
      @(posedge clk);
      #1;
      if (r) begin
        acc = cyc;
        break;
      end
    end
    bus.cmd_valid = 1'b0;
    if (acc < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout: got no accept want accept within 100 cycles");
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (bus.busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (bus.busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got busy=1 want busy=0 within 200 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rises(input string nm, input logic [63:0] exp[$], input bit spaced);
    chk({nm, "_count"}, rise_dat.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rise_dat.size(); i++) begin
      chk({nm, "_data"}, rise_dat[i], exp[i]);
      if (spaced && i > 0) chk({nm, "_spacing"}, rise_cyc[i] - rise_cyc[i-1], H + G + 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish within 100000 time units");
    $fatal(1);
  end

  initial begin
    int          acc;
    int          gap;
    logic [63:0] exp[$];
    logic [31:0] a;
    logic [31:0] b;
    bit          wrap_done;

    bus.cmd_valid = 1'b0;
    bus.cmd_dataA = '0;
    bus.cmd_dataB = '0;
    bus.wrfull    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    cmp_en = 1;

    // Reset state
    @(negedge clk);
    chk("rst_level", bus.level, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_wrreg", bus.wrreg, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_dataA", bus.dataA, 0);

    // Single command: pop at E1, wrreg E1..E2, low E3..E4, busy drops at E5
    @(posedge clk);
    #1;
    push_cmd(32'h0000_0010, 32'h1234_5678, acc);
    @(negedge clk);
    chk("single_E0_level", bus.level, 1);
    chk("single_E0_wrreg", bus.wrreg, 0);
    @(negedge clk);
    chk("single_E1_wrreg", bus.wrreg, 1);
    chk("single_E1_dataA", bus.dataA, 32'h0000_0010);
    chk("single_E1_dataB", bus.dataB, 32'h1234_5678);
    @(negedge clk);
    chk("single_E2_wrreg", bus.wrreg, 1);
    @(negedge clk);
    chk("single_E3_wrreg", bus.wrreg, 0);
    @(negedge clk);
    chk("single_E4_wrreg", bus.wrreg, 0);
    chk("single_E4_busy", bus.busy, 1);
    @(negedge clk);
    chk("single_E5_busy", bus.busy, 0);
    chk("single_E5_dataA", bus.dataA, 32'h0000_0010);
    @(posedge clk);
    #1;

    // Back-pressure with 3 queued, then release
    rise_cyc.delete();
    rise_dat.delete();
    exp.delete();
    bus.wrfull = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = $urandom();
      b = $urandom();
      exp.push_back({a, b});
      push_cmd(a, b, acc);
    end
    repeat (4) @(negedge clk);
    chk("bp_level", bus.level, 3);
    chk("bp_wrreg", bus.wrreg, 0);
    chk("bp_dataA", bus.dataA, 32'h0000_0010);
    @(posedge clk);
    #1;
    bus.wrfull = 1'b0;
    wait_idle();
    chk_rises("bp", exp, 1);

    // Fill: 8 accepted under wrfull, 9th held until one cycle after the first pop
    rise_cyc.delete();
    rise_dat.delete();
    exp.delete();
    bus.wrfull = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = $urandom();
      b = $urandom();
      exp.push_back({a, b});
      push_cmd(a, b, acc);
    end
    a = $urandom();
    b = $urandom();
    exp.push_back({a, b});
    fork
      push_cmd(a, b, acc);
      begin
        repeat (3) @(negedge clk);
        chk("fill_level", bus.level, 8);
        chk("fill_ready", bus.cmd_ready, 0);
        @(posedge clk);
        #1;
        bus.wrfull = 1'b0;
      end
    join
    if (rise_cyc.size() > 0) chk("fill_ninth_accept", acc, rise_cyc[0] + 1);
    else chk("fill_first_pop", rise_cyc.size(), 1);
    wait_idle();
    chk_rises("fill", exp, 1);

    // Wrap-around: 20 random commands, random valid gaps and wrfull
    rise_cyc.delete();
    rise_dat.delete();
    exp.delete();
    wrap_done = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          a = $urandom();
          b = $urandom();
          exp.push_back({a, b});
          push_cmd(a, b, acc);
          gap = $urandom_range(0, 3);
          repeat (gap) begin
            @(posedge clk);
            #1;
          end
        end
        wrap_done = 1;
      end
      begin
        while (!wrap_done) begin
          @(posedge clk);
          #1;
          bus.wrfull = ($urandom_range(0, 3) == 0);
        end
        bus.wrfull = 1'b0;
      end
    join
    wait_idle();
    chk_rises("wrap", exp, 0);

    // Mid-operation reset with 4 still queued
    rise_cyc.delete();
    rise_dat.delete();
    bus.wrfull = 1'b1;
    for (int i = 0; i < 5; i++) push_cmd($urandom(), $urandom(), acc);
    bus.wrfull = 1'b0;
    for (int k = 0; k < 20 && rise_cyc.size() == 0; k++) @(negedge clk);
    chk("mrst_issued", rise_cyc.size(), 1);
    chk("mrst_pre_level", bus.level, 4);
    #3;
    reset = 1'b0;
    #1;
    chk("mrst_wrreg", bus.wrreg, 0);
    chk("mrst_level", bus.level, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_dataA", bus.dataA, 0);
    chk("mrst_ready", bus.cmd_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    rise_cyc.delete();
    rise_dat.delete();
    repeat (20) @(posedge clk);
    #1;
    chk("mrst_no_stale", rise_dat.size(), 0);
    chk("mrst_post_level", bus.level, 0);

`ifdef GPU_CMD_SENDER_STATS_EN
    // 3 commands stalled for 7 edges, then drained
    bus.wrfull = 1'b1;
    for (int i = 0; i < 3; i++) push_cmd($urandom(), $urandom(), acc);
    repeat (5) @(posedge clk);
    #1;
    bus.wrfull = 1'b0;
    wait_idle();
    chk("stats_issued", issued_count, 3);
    chk("stats_stall", stall_count, 7);
`endif

    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
